// File: rtl/struct_unpacker.sv
// struct_unpacker: takes one packed record (15-bit tail field plus 25 byte
// fields) and emits it one field per beat over a valid/ready stream.
// The emission order is index 0 (tail) up to index N_FIELDS.
module struct_unpacker #(
  parameter int W_TAIL   = 15,
  parameter int W_FIELD  = 8,
  parameter int N_FIELDS = 25
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic                                               in_valid,
  output logic                                               in_ready,
  input  logic [W_TAIL+W_FIELD*N_FIELDS-1:0]                 in_data,
  output logic                                               out_valid,
  input  logic                                               out_ready,
  output logic [((W_TAIL > W_FIELD) ? W_TAIL : W_FIELD)-1:0] out_data,
  output logic [4:0]                                         out_index,
  output logic                                               out_last,
  output logic                                               busy
);

  localparam int         W_REC    = W_TAIL + W_FIELD * N_FIELDS;
  localparam int         W_OUT    = (W_TAIL > W_FIELD) ? W_TAIL : W_FIELD;
  localparam logic [4:0] LAST_IDX = 5'(N_FIELDS);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             r_state;
  logic [W_REC-1:0]   r_hold;
  logic [4:0]         r_index;
  logic [W_OUT-1:0]   w_field;

  // FSM: latch a record in IDLE, then walk the field index in SEND
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_index <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_hold  <= in_data;
            r_index <= '0;
            r_state <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (r_index == LAST_IDX) begin
              r_index <= '0;
              r_state <= IDLE;
            end else begin
              r_index <= r_index + 5'd1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_index <= '0;
        end
      endcase
    end
  end

  // Field select: index mux over the held record, zero-extended to W_OUT
  always_comb begin
    w_field = W_OUT'(r_hold[W_TAIL-1:0]);
    for (int unsigned k = 1; k <= N_FIELDS; k++) begin
      if (r_index == 5'(k)) begin
        w_field = W_OUT'(r_hold[W_TAIL+W_FIELD*(k-1) +: W_FIELD]);
      end
    end
  end

  // Outputs are decoded from registered state only; data reads zero when idle
  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == SEND);
    busy      = (r_state == SEND);
    out_index = r_index;
    out_last  = (r_state == SEND) && (r_index == LAST_IDX);
    out_data  = (r_state == SEND) ? w_field : '0;
  end

endmodule

// File: tb/tb_struct_unpacker.sv
// Scoreboard bench for struct_unpacker: stimulus pushes expected beats,
// a negedge monitor pops and compares every accepted output beat.
module tb_struct_unpacker;

  localparam int W_REC = 215;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [W_REC-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [14:0]       out_data;
  logic [4:0]        out_index;
  logic              out_last;
  logic              busy;

  always #5 clk = ~clk;

  struct_unpacker #(.W_TAIL(15), .W_FIELD(8), .N_FIELDS(25)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy)
  );

  typedef struct packed {
    logic [4:0]  idx;
    logic [14:0] data;
    logic        last;
  } beat_t;

  beat_t        sb[$];
  int unsigned  errs   = 0;
  int unsigned  checks = 0;
  int unsigned  beats  = 0;

  logic [14:0]  exp_f [26];
  logic [14:0]  st_tail;
  logic [7:0]   st_f [1:25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [W_REC-1:0] build();
    logic [W_REC-1:0] r;
    r = '0;
    r[14:0] = st_tail;
    for (int k = 1; k <= 25; k++) r[15+8*(k-1) +: 8] = st_f[k];
    return r;
  endfunction

  // Basic pattern: byte field k holds k, tail zero; expected beats 0..25
  task automatic set_basic();
    st_tail = '0;
    for (int k = 1; k <= 25; k++) st_f[k] = 8'(k);
    for (int k = 0; k <= 25; k++) exp_f[k] = 15'(k);
  endtask

  task automatic push_exp();
    for (int k = 0; k <= 25; k++)
      sb.push_back('{idx: 5'(k), data: exp_f[k], last: (k == 25)});
  endtask

  // Offer a record once in_ready is high; expectations queued at acceptance
  task automatic send(input logic [W_REC-1:0] d);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("send_wait", 32'(n < 200), 1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    push_exp();
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk("drain", 32'(n < 300), 1);
  endtask

  // Monitor: every beat accepted by the consumer must match the queue head
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && out_valid && out_ready) begin
      beats++;
      if (sb.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_beat: got index %0d data 0x%0h expected none", out_index, out_data);
      end else begin
        e = sb.pop_front();
        chk("beat_index", 32'(out_index), 32'(e.idx));
        chk("beat_data",  32'(out_data),  32'(e.data));
        chk("beat_last",  32'(out_last),  32'(e.last));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W_REC-1:0] rec;
    int unsigned      b0;
    int               n;
    bit               d5, d25;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #12;
    chk("rst_in_ready",  32'(in_ready),  1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data",  32'(out_data),  0);
    chk("rst_out_index", 32'(out_index), 0);
    chk("rst_out_last",  32'(out_last),  0);
    chk("rst_busy",      32'(busy),      0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic record with latency and throughput checks
    set_basic();
    send(build());
    chk("latency_valid", 32'(out_valid), 1);
    chk("latency_index", 32'(out_index), 0);
    chk("in_ready_low",  32'(in_ready),  0);
    repeat (25) @(posedge clk);
    #1 chk("in_ready_before_27", 32'(in_ready), 0);
    @(posedge clk);
    #1 chk("in_ready_at_27", 32'(in_ready), 1);
    drain();

    // Patched record: nibbles inside fields 3 and 11
    set_basic();
    rec = build();
    rec[36:33] = 4'hB;
    rec[99:96] = 4'hA;
    exp_f[3]  = 15'h002F;
    exp_f[11] = 15'h0015;
    send(rec);
    drain();

    // Tail width: all ones everywhere
    st_tail = 15'h7FFF;
    for (int k = 1; k <= 25; k++) st_f[k] = 8'hFF;
    exp_f[0] = 15'h7FFF;
    for (int k = 1; k <= 25; k++) exp_f[k] = 15'h00FF;
    send(build());
    drain();

    // Backpressure: 3-cycle stall at index 5, 1-cycle stall at index 25
    set_basic();
    b0 = beats;
    send(build());
    n = 0; d5 = 0; d25 = 0;
    while (!(d5 && d25) && n < 100) begin
      if (out_valid && out_index == 5'd5 && !d5) begin
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall5_data",  32'(out_data),  5);
          chk("stall5_index", 32'(out_index), 5);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
        d5 = 1;
      end else if (out_valid && out_index == 5'd25 && !d25) begin
        out_ready = 1'b0;
        @(negedge clk);
        chk("stall25_data", 32'(out_data), 25);
        chk("stall25_last", 32'(out_last), 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        d25 = 1;
      end else begin
        @(posedge clk); #1; n++;
      end
    end
    chk("stalls_seen", 32'({d5, d25}), 3);
    drain();
    chk("bp_beat_count", beats - b0, 26);

    // Reset mid-record at index 10, then a fresh 0x80+k record
    set_basic();
    send(build());
    n = 0;
    while (out_index != 5'd10 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("reach_index10", 32'(n < 100), 1);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_busy",  32'(busy),      0);
    @(negedge clk); #1 rst_n = 1'b1;
    chk("post_rst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    st_tail = '0;
    for (int k = 1; k <= 25; k++) st_f[k] = 8'h80 + 8'(k);
    exp_f[0] = 15'h0000;
    for (int k = 1; k <= 25; k++) exp_f[k] = 15'h0080 + 15'(k);
    send(build());
    chk("post_rst_first_index", 32'(out_index), 0);
    drain();

    // Input activity while busy must be ignored
    set_basic();
    rec = build();
    send(rec);
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid;
      in_data  = ~in_data;
      @(posedge clk); #1;
      chk("busy_in_ready", 32'(in_ready), 0);
      chk("busy_flag",     32'(busy),     1);
    end
    in_valid = 1'b0;
    drain();
    chk("sb_empty_end", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/struct_unpacker.md
# struct_unpacker

Serializes one 215-bit packed record word back into its individual fields, one field per beat, over a valid/ready stream. It is the read-side counterpart of the record packer, which assembles 25 byte fields and one 15-bit tail field into a single vector. The block sits between a record-producing pipeline stage and any narrow consumer that walks fields in index order.

## Interface
Parameters:
- W_TAIL, 15, width of field 0, the tail field at the LSB end.
- W_FIELD, 8, width of each byte field 1..N_FIELDS.
- N_FIELDS, 25, number of byte fields. Record width W_REC = W_TAIL + W_FIELD*N_FIELDS, which is 215.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, the record on in_data is offered.
- in_ready, output, 1, the block can accept a record.
- in_data, input, W_REC, packed record.
- out_valid, output, 1, a field is presented.
- out_ready, input, 1, the consumer accepts the field.
- out_data, output, max(W_TAIL,W_FIELD), field value, zero-extended.
- out_index, output, 5, field index, 0..N_FIELDS.
- out_last, output, 1, high on the final field (index N_FIELDS).
- busy, output, 1, a record is held (the state is SEND).

## Operation
- Field map:
  - index 0 is in_data[W_TAIL-1:0].
  - index k ≥ 1 is in_data[W_TAIL+W_FIELD*k-1 : W_TAIL+W_FIELD*(k-1)].
  - With the defaults, k=1 is [22:15] and k=25 is [214:207].
- Emission order is ascending index 0,1,…,25. A record produces 26 beats.
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
    - If in_valid, latch in_data into an internal hold register, clear the index counter, and go to SEND.
  - SEND: in_ready=0, out_valid=1.
    - out_data is the field at the current index.
    - On out_valid && out_ready with index < N_FIELDS, increment the index.
    - On out_valid && out_ready with index == N_FIELDS, go to IDLE.
- out_last = (index == N_FIELDS) while in SEND.
- The hold register is written only on acceptance in IDLE. A change of in_data during SEND has no effect.
- Implementation choice: either a right shift of the hold register by the field width per beat, or an index mux. Both are acceptable if the outputs are identical.

## Timing
- All outputs are registered or decoded from registered state only. There is no combinational path from in_valid or out_ready to any output.
- Reset values: in_ready=1, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, FSM in IDLE.
- Latency: a record accepted at edge t has index 0 valid after edge t, i.e. out_valid is visible in cycle t+1.
- Throughput:
  - With out_ready held high, there are 26 output beats plus 1 IDLE cycle, so a new record is accepted every 27 cycles.
  - in_ready rises in the cycle after the last beat is accepted.
- Backpressure: while out_valid && !out_ready, out_data, out_index and out_last must hold stable.
- Reset mid-record: asserting rst_n low forces IDLE asynchronously and drops out_valid immediately. The partial record is discarded. After release, the next beat comes from a newly accepted record starting at index 0.
- An in_valid asserted during SEND is ignored (in_ready=0). The upstream must hold its record until in_ready is high.
- The index counter never exceeds N_FIELDS. There is no wrap: leaving SEND is the only exit from index N_FIELDS.

## Test plan
- Basic record:
  - Stimulus: in_data with field k = k for k=1..25, tail = 0, out_ready held 1.
  - Required: the out_data sequence is 0,1,2,…,25; out_last only on index 25; first out_valid one cycle after acceptance; in_ready high again 27 cycles after the first acceptance.
- Patched record:
  - Stimulus: the same record, then bits [36:33] set to 4'hB and [99:96] set to 4'hA.
  - Required: field 3 = 47 (0x2F), field 11 = 21 (0x15), all other fields unchanged.
- Backpressure:
  - Stimulus: the basic record, with out_ready deasserted for 3 cycles at index 5 and for 1 cycle at index 25.
  - Required: out_data=5 and out_data=25 are held stable through each stall; no field is dropped or duplicated; 26 accepted beats in total.
- Tail width:
  - Stimulus: tail = 15'h7FFF, all bytes = 8'hFF.
  - Required: index 0 returns 0x7FFF; indices 1–25 return 0x00FF, with the upper 7 bits zero.
- Reset mid-record:
  - Stimulus: pull rst_n low asynchronously (mid-cycle) at index 10, release, then offer a record with field k = 8'h80+k.
  - Required: out_valid falls without waiting for a clock edge; in_ready=1 after release; the next beats are 0, 0x81, … from index 0.
- Input ignored while busy:
  - Stimulus: toggle in_valid and in_data during SEND.
  - Required: in_ready stays 0 and the emitted fields match the record originally latched.
